// File: rtl/core_pkg.sv
// Shared encodings for the core memory arbiter: FSM states and host status codes.
package core_pkg;

  typedef enum logic [2:0] {
    S_HOST = 3'd0,
    S_ARB  = 3'd1,
    S_RESP = 3'd2,
    S_HOLD = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [1:0] ST_HOST = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first requester at or after ptr, wrapping modulo NUM_CORES.
module rr_picker #(
  parameter int NUM_CORES = 4,
  parameter int PTR_W     = 2
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic                 valid,
  output logic [PTR_W-1:0]     idx
);

  // Scan offsets from farthest to nearest so the nearest requester wins last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_CORES]) begin
        valid = 1'b1;
        idx   = PTR_W'((int'(ptr) + k) % NUM_CORES);
      end
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one data-memory port between the host loader and NUM_CORES cores.
// Core handshake: a core raises core_req[i] (with we/addr/wdata stable) and
// holds it until it sees core_ack[i]; core_ack is a one-cycle, one-hot pulse
// and core_rdata is valid only in that cycle. The memory returns read data one
// cycle after mem_en, so each access occupies an S_ARB and an S_RESP cycle.
module core_mem_arbiter
  import core_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  status,
  input  logic [DATA_W-1:0]           com_data_in,
  input  logic [ADDR_W-1:0]           com_addr,
  input  logic                        com_wr_en,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  input  logic [NUM_CORES-1:0]        core_done,
  output logic [NUM_CORES-1:0]        core_ack,
  output logic [DATA_W-1:0]           core_rdata,
  output logic                        core_start,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        end_process
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, grant, pick_idx;
  logic               pick_valid;
  logic               latch_en;
  logic               start_nxt;
  // Set once status has been seen at HOST; a run can only start after that,
  // so coming out of reset with status already at RUN does not start the cores.
  logic               host_seen;

  rr_picker #(.NUM_CORES(NUM_CORES), .PTR_W(PTR_W)) u_picker (
    .req   (core_req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Next-state and all combinational outputs; every output defaults to 0.
  always_comb begin
    state_nxt   = state;
    latch_en    = 1'b0;
    start_nxt   = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    core_ack    = '0;
    core_rdata  = '0;
    end_process = 1'b0;
    case (state)
      S_HOST: begin
        if (com_wr_en) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = com_addr;
          mem_wdata = com_data_in;
        end
        if (status == ST_RUN && host_seen) begin
          state_nxt = S_ARB;
          start_nxt = 1'b1;
        end
      end
      S_ARB: begin
        if (status == ST_HOST) begin
          state_nxt = S_HOST;
        end else if (status[1]) begin
          state_nxt = S_HOLD;
        end else if (&core_done) begin
          state_nxt = S_DONE;
        end else if (pick_valid) begin
          mem_en    = 1'b1;
          mem_we    = core_we[pick_idx];
          mem_addr  = core_addr[pick_idx*ADDR_W +: ADDR_W];
          mem_wdata = core_wdata[pick_idx*DATA_W +: DATA_W];
          latch_en  = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        core_ack[grant] = 1'b1;
        core_rdata      = mem_rdata;
        state_nxt       = S_ARB;
      end
      S_HOLD: begin
        if (status == ST_RUN)       state_nxt = S_ARB;
        else if (status == ST_HOST) state_nxt = S_HOST;
      end
      S_DONE: begin
        end_process = 1'b1;
        if (status == ST_HOST) state_nxt = S_HOST;
      end
      default: state_nxt = S_HOST;
    endcase
  end

  // State, grant latch, round-robin pointer, start pulse and host-seen flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_HOST;
      rr_ptr     <= '0;
      grant      <= '0;
      core_start <= 1'b0;
      host_seen  <= 1'b0;
    end else begin
      state      <= state_nxt;
      core_start <= start_nxt;
      if (latch_en) grant <= pick_idx;
      if (state == S_RESP) begin
        rr_ptr <= (grant == PTR_W'(NUM_CORES - 1)) ? '0 : grant + 1'b1;
      end
      if (status == ST_HOST)  host_seen <= 1'b1;
      else if (start_nxt)     host_seen <= 1'b0;
    end
  end

endmodule
